// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-requester BRAM arbiter.
//   BRAM_W / DATA_W : BRAM address and data widths
//   BRAM_SIZE       : number of BRAM words; requester addresses at or above it are rejected
//   owner_t         : which requester held the grant on the previous cycle
//   pend_t          : read-return / error-return slot captured at grant time
package mem_arb_pkg;

  localparam int BRAM_W    = 10;
  localparam int DATA_W    = 32;
  localparam int BRAM_SIZE = 1 << BRAM_W;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic valid;  // a read was issued last cycle
    logic who;    // 0 = M0, 1 = M1
    logic err;    // the issued access was out of range
  } pend_t;

endpackage

// File: rtl/bram_arbiter_if.sv
// One requester's connection to the arbiter.
//   master : requester side (drives req/addr/write/wdata, sees gnt/rvalid/rdata/err)
//   slave  : arbiter side
interface bram_req_if #(
  parameter int ADDR_W = 32
);
  import mem_arb_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, addr, write, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, addr, write, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/bram_arbiter_rr_pick.sv
// Two-way grant picker, purely combinational.
//   req[1:0]  : request from M1 (bit 1) and M0 (bit 0)
//   owner     : requester granted on the previous cycle (OWN_NONE after an idle cycle)
//   burst_cnt : consecutive grants given to owner, saturating at MAX_BURST
//   last      : most recent grantee (0 = M0, 1 = M1)
//   gnt[1:0]  : one-hot grant, or zero when nobody requests
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic [1:0]       req,
  input  owner_t           owner,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             last,
  output logic [1:0]       gnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    gnt = 2'b00;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        unique case (owner)
          OWN_M0:  gnt = (burst_cnt < MAX_CNT) ? 2'b01 : 2'b10;
          OWN_M1:  gnt = (burst_cnt < MAX_CNT) ? 2'b10 : 2'b01;
          // Fresh contention: whoever did not go last wins the tie.
          default: gnt = last ? 2'b01 : 2'b10;
        endcase
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one BRAM port between M0 (CPU) and M1 (loader/DMA). One access is
// issued per cycle with bounded-burst fairness; read data returns one cycle
// after the grant with a valid strobe routed to the issuing requester.
//   clk, rst_n     : clock, async active-low reset
//   m0, m1         : requester buses (req/addr/write/wdata in, gnt/rvalid/rdata/err out)
//   bram_addr      : BRAM word address (zero when nothing is issued)
//   bram_write     : BRAM write enable
//   bram_data_in   : BRAM write data
//   bram_data_out  : BRAM read data, valid one cycle after the address
module bram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_req_if.slave         m0,
  bram_req_if.slave         m1,
  output logic [BRAM_W-1:0] bram_addr,
  output logic              bram_write,
  output logic [DATA_W-1:0] bram_data_in,
  input  logic [DATA_W-1:0] bram_data_out
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_q, last_d;
  pend_t            pend_q, pend_d;

  logic [1:0]        gnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_write;
  logic [DATA_W-1:0] sel_wdata;
  logic              oob;
  owner_t            new_owner;

  rr_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req       ({m1.req, m0.req}),
    .owner     (owner_q),
    .burst_cnt (burst_cnt_q),
    .last      (last_q),
    .gnt       (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel_addr  = gnt[1] ? m1.addr  : m0.addr;
  assign sel_write = gnt[1] ? m1.write : m0.write;
  assign sel_wdata = gnt[1] ? m1.wdata : m0.wdata;
  // Any set bit above the BRAM index field means the address is past the end.
  assign oob       = |sel_addr[ADDR_W-1:BRAM_W];
  assign new_owner = gnt[1] ? OWN_M1 : OWN_M0;

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // BRAM drive: zero unless an in-range access is issued this cycle.
  always_comb begin
    bram_addr    = '0;
    bram_write   = 1'b0;
    bram_data_in = '0;
    if (any_gnt && !oob) begin
      bram_addr    = sel_addr[BRAM_W-1:0];
      bram_write   = sel_write;
      bram_data_in = sel_wdata;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    burst_cnt_d = '0;
    last_d      = last_q;
    if (any_gnt) begin
      owner_d     = new_owner;
      last_d      = gnt[1];
      if (owner_q == new_owner)
        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + 1'b1;
      else
        burst_cnt_d = CNT_W'(1);
    end
    // Out-of-range writes also land here (valid=0, err=1) so the error
    // pulse comes back one cycle after the grant just like a read.
    pend_d.valid = any_gnt && !sel_write;
    pend_d.who   = gnt[1];
    pend_d.err   = any_gnt && oob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;  // M1 went "last" so M0 wins the first tie
      pend_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
    end
  end

  // Return path: BRAM output already lags the address by one cycle, so it
  // lines up with the pending slot captured at grant time.
  assign m0.rvalid = pend_q.valid && !pend_q.who;
  assign m1.rvalid = pend_q.valid &&  pend_q.who;
  assign m0.err    = pend_q.err   && !pend_q.who;
  assign m1.err    = pend_q.err   &&  pend_q.who;
  assign m0.rdata  = (m0.rvalid && !pend_q.err) ? bram_data_out : '0;
  assign m1.rdata  = (m1.rvalid && !pend_q.err) ? bram_data_out : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed stimulus, grant/BRAM-drive
// checks in the issue cycle, and a scoreboard monitor for the return path.
module tb_bram_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_req_if #(.ADDR_W(32)) m0_bus ();
  bram_req_if #(.ADDR_W(32)) m1_bus ();

  logic [BRAM_W-1:0] bram_addr;
  logic              bram_write;
  logic [DATA_W-1:0] bram_data_in;
  logic [DATA_W-1:0] bram_data_out;

  bram_arbiter #(.MAX_BURST(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .bram_addr     (bram_addr),
    .bram_write    (bram_write),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out)
  );

  // Behavioural BRAM: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] mem [0:BRAM_SIZE-1];
  initial begin
    for (int i = 0; i < BRAM_SIZE; i++) mem[i] = 32'hA500_0000 | i;
    bram_data_out = '0;
  end
  always @(posedge clk) begin
    if (bram_write) mem[bram_addr] <= bram_data_in;
    bram_data_out <= mem[bram_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        who;
    logic        rv;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input logic who, input logic rv, input logic err, input logic [31:0] data);
    exp_t e;
    e.who = who; e.rv = rv; e.err = err; e.data = data;
    exp_q.push_back(e);
  endtask

  // Return-path monitor: any rvalid/err strobe must match the oldest expectation.
  always @(negedge clk) begin
    logic [67:0] act, exp;
    exp_t e;
    act = {m0_bus.rvalid, m0_bus.err, m0_bus.rdata, m1_bus.rvalid, m1_bus.err, m1_bus.rdata};
    if (rst_n && (act[67] || act[66] || act[33] || act[32])) begin
      if (exp_q.size() == 0) begin
        check("unexpected_return", {60'd0, act}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        exp = e.who ? {34'd0, e.rv, e.err, e.data} : {e.rv, e.err, e.data, 34'd0};
        check("return", {60'd0, act}, {60'd0, exp});
      end
    end
  end

  function automatic logic [112:0] all_outs();
    return {m0_bus.gnt, m0_bus.rvalid, m0_bus.err, m0_bus.rdata,
            m1_bus.gnt, m1_bus.rvalid, m1_bus.err, m1_bus.rdata,
            bram_addr, bram_write, bram_data_in};
  endfunction

  // One cycle: drive requests just after the edge, then settle to the negedge.
  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    m0_bus.req = r0; m0_bus.write = w0; m0_bus.addr = a0; m0_bus.wdata = d0;
    m1_bus.req = r1; m1_bus.write = w1; m1_bus.addr = a1; m1_bus.wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_issue(input string name, input logic [1:0] gnt, input logic [9:0] addr,
                           input logic we, input logic [31:0] din);
    check({name, "_gnt"}, {126'd0, m1_bus.gnt, m0_bus.gnt}, {126'd0, gnt});
    check({name, "_bram"}, {85'd0, bram_addr, bram_write, bram_data_in}, {85'd0, addr, we, din});
  endtask

  initial begin
    m0_bus.req = 0; m0_bus.write = 0; m0_bus.addr = 0; m0_bus.wdata = 0;
    m1_bus.req = 0; m1_bus.write = 0; m1_bus.addr = 0; m1_bus.wdata = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {15'd0, all_outs()}, 128'd0);
    rst_n = 1'b1;

    // M0 write then read back
    cyc(1, 1, 32'h10, 32'hAB, 0, 0, 0, 0);
    chk_issue("m0_write", 2'b01, 10'h10, 1'b1, 32'hAB);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk_issue("m0_read", 2'b01, 10'h10, 1'b0, 32'h0);
    push(0, 1, 0, 32'h0000_00AB);
    idle();

    // Out-of-range read and write on M1
    cyc(0, 0, 0, 0, 1, 0, BRAM_SIZE, 0);
    chk_issue("m1_oob_read", 2'b10, 10'h0, 1'b0, 32'h0);
    push(1, 1, 1, 32'h0);
    cyc(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
    chk_issue("m1_oob_write", 2'b10, 10'h0, 1'b0, 32'h0);
    push(1, 0, 1, 32'h0);
    idle();

    // Alternating single-cycle reads, back-to-back returns
    cyc(1, 0, 32'h1, 0, 0, 0, 0, 0);
    chk_issue("alt0", 2'b01, 10'h1, 1'b0, 32'h0);
    push(0, 1, 0, 32'hA500_0001);
    cyc(0, 0, 0, 0, 1, 0, 32'h2, 0);
    chk_issue("alt1", 2'b10, 10'h2, 1'b0, 32'h0);
    push(1, 1, 0, 32'hA500_0002);
    cyc(1, 0, 32'h3, 0, 0, 0, 0, 0);
    chk_issue("alt2", 2'b01, 10'h3, 1'b0, 32'h0);
    push(0, 1, 0, 32'hA500_0003);
    idle();
    idle();

    // Reset arriving between a read grant and its capture edge
    cyc(1, 0, 32'h5, 0, 0, 0, 0, 0);
    chk_issue("pre_reset_read", 2'b01, 10'h5, 1'b0, 32'h0);
    rst_n = 1'b0;
    m0_bus.req = 0;
    #1;
    check("midreset_outputs", {15'd0, all_outs()}, 128'd0);
    repeat (2) @(negedge clk);
    check("midreset_hold", {15'd0, all_outs()}, 128'd0);
    rst_n = 1'b1;

    // Contention from reset: M0 x4, M1 x4, M0 x4
    for (int i = 0; i < 12; i++) begin
      logic [1:0] g;
      g = (i >= 4 && i < 8) ? 2'b10 : 2'b01;
      cyc(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      chk_issue($sformatf("contend%0d", i), g, g[1] ? 10'h30 : 10'h20, 1'b0, 32'h0);
      if (g[1]) push(1, 1, 0, 32'hA500_0030);
      else      push(0, 1, 0, 32'hA500_0020);
    end
    idle();

    // Idle gap: M0 burst of 2, one idle cycle, then both request -> M1 wins
    cyc(1, 0, 32'h7, 0, 0, 0, 0, 0);
    push(0, 1, 0, 32'hA500_0007);
    cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
    push(0, 1, 0, 32'hA500_0008);
    idle();
    cyc(1, 0, 32'h9, 0, 1, 0, 32'hA, 0);
    chk_issue("gap_tie", 2'b10, 10'hA, 1'b0, 32'h0);
    push(1, 1, 0, 32'hA500_000A);
    idle();
    repeat (3) idle();

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
